// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment patterns, FSM states and widths for the 7-segment capture block
package seven_seg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;
  localparam logic [SEG_W-1:0] SEG_PAT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                                SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  typedef enum logic [1:0] {ST_SYNC, ST_SETTLE, ST_HELD} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: map a gfedcba segment pattern back to its hex nibble
module seg7_decode import seven_seg_pkg::*; (
  input  logic [SEG_W-1:0] seg_i,
  output logic             ok_o,
  output logic [3:0]       nib_o
);
  // table search; patterns not in the table read as 0 with ok_o low
  always_comb begin
    ok_o = 1'b0;
    nib_o = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_PAT[i]) begin
        ok_o = 1'b1;
        nib_o = 4'(i);
      end
    end
  end
endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: rebuild the two-digit word from a multiplexed 7-segment bus
module seven_seg_capture import seven_seg_pkg::*; #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 2047
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEG_W-1:0]     seg_in,
  input  logic                 sel_in,
  output logic [2*SEG_W-1:0]   both7seg_out,
  output logic                 frame_valid,
  output logic [3:0]           hex_hi,
  output logic [3:0]           hex_lo,
  output logic                 hex_ok,
  output logic                 stale
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [SEG_W-1:0] r_seg_q, p_seg_q, hi_q;
  logic             r_sel_q, p_sel_q, hi_f_q;
  logic [7:0]       cnt_q, cnt_d;
  logic [TW-1:0]    tcnt_q;
  state_t           state_q;
  logic             sel_edge, seg_chg, step, cap, stale_hit;
  logic             ok_hi, ok_lo;
  logic [3:0]       nib_hi, nib_lo;

  seg7_decode u_dec_hi (.seg_i(hi_q), .ok_o(ok_hi), .nib_o(nib_hi));
  seg7_decode u_dec_lo (.seg_i(r_seg_q), .ok_o(ok_lo), .nib_o(nib_lo));

  // change detection on the registered bus; a step re-evaluates the settle count
  always_comb begin
    sel_edge = r_sel_q ^ p_sel_q;
    seg_chg = r_seg_q != p_seg_q;
    step = sel_edge || state_q == ST_SETTLE || (state_q == ST_HELD && seg_chg);
    cnt_d = (sel_edge || seg_chg) ? 8'd1 : cnt_q + 8'd1;
    cap = step && cnt_d == 8'(SETTLE);
    stale_hit = !sel_edge && tcnt_q == TW'(TIMEOUT - 1);
  end

  // input register, capture FSM, frame assembly and link timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q <= '0;
      p_seg_q <= '0;
      r_sel_q <= 1'b0;
      p_sel_q <= 1'b0;
      hi_q <= '0;
      hi_f_q <= 1'b0;
      cnt_q <= '0;
      tcnt_q <= '0;
      state_q <= ST_SYNC;
      both7seg_out <= '0;
      frame_valid <= 1'b0;
      hex_hi <= '0;
      hex_lo <= '0;
      hex_ok <= 1'b0;
      stale <= 1'b0;
    end else begin
      r_seg_q <= seg_in;
      r_sel_q <= sel_in;
      p_seg_q <= r_seg_q;
      p_sel_q <= r_sel_q;
      frame_valid <= 1'b0;
      if (sel_edge) tcnt_q <= '0;
      else if (tcnt_q != TW'(TIMEOUT)) tcnt_q <= tcnt_q + TW'(1);
      if (stale_hit) begin
        stale <= 1'b1;
        hi_f_q <= 1'b0;
        state_q <= ST_SYNC;
      end else if (step) begin
        if (sel_edge) stale <= 1'b0;
        cnt_q <= cnt_d;
        state_q <= cap ? ST_HELD : ST_SETTLE;
        if (state_q == ST_HELD && !sel_edge && r_sel_q) hi_f_q <= 1'b0;
        if (cap && r_sel_q) begin
          hi_q <= r_seg_q;
          hi_f_q <= 1'b1;
        end
        if (cap && !r_sel_q && hi_f_q) begin
          both7seg_out <= {hi_q, r_seg_q};
          hex_hi <= nib_hi;
          hex_lo <= nib_lo;
          hex_ok <= ok_hi & ok_lo;
          frame_valid <= 1'b1;
          hi_f_q <= 1'b0;
        end
      end
    end
  end
endmodule
